// File: rtl/sprite_engine.sv
// sprite_engine
//   Overlays a WxH (optionally 2x replicated) multi-frame sprite onto the
//   incoming background pixel. Position and visibility take effect only at
//   frame start, so the sprite cannot tear. An animation frame counter steps
//   every FRAME_HOLD frame starts. Sprite pixels come from an external
//   synchronous ROM. A per-channel tolerance colour key makes pixels
//   transparent.
//
//   clk         pixel clock
//   rst         synchronous active-high reset
//   bright      display-active flag
//   hCount      pixel column
//   vCount      pixel row
//   background  pixel colour beneath the sprite
//   pos_x/pos_y requested sprite top-left corner; loaded on pos_we
//   visible     sprite enable, sampled at frame start
//   anim_en     animation advance enable
//   rom_addr    ROM read address (registered)
//   rom_data    ROM pixel, valid ROM_LAT cycles after rom_addr
//   rgb         output pixel, ROM_LAT+2 cycles after the inputs
//   sprite_hit  opaque sprite pixel on rgb
//   cur_frame   displayed animation frame
module sprite_engine #(
    parameter int          W          = 32,
    parameter int          H          = 32,
    parameter int          NUM_FRAMES = 4,
    parameter int          FRAME_HOLD = 8,
    parameter int          SCALE      = 1,
    parameter int          ROM_LAT    = 1,
    parameter logic [11:0] KEY_COLOR  = 12'hF0F,
    parameter int          KEY_TOL    = 1,
    parameter int          INIT_X     = 100,
    parameter int          INIT_Y     = 100,
    parameter int          ADDR_W     = $clog2(NUM_FRAMES * W * H),
    localparam int         FW         = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bright,
    input  logic [9:0]        hCount,
    input  logic [9:0]        vCount,
    input  logic [11:0]       background,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic              pos_we,
    input  logic              visible,
    input  logic              anim_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [11:0]       rom_data,
    output logic [11:0]       rgb,
    output logic              sprite_hit,
    output logic [FW-1:0]     cur_frame
);

    localparam int          HCW         = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
    localparam int          SH          = (SCALE == 2) ? 1 : 0;
    localparam logic [10:0] SPAN_X      = 11'(W * SCALE);
    localparam logic [10:0] SPAN_Y      = 11'(H * SCALE);
    localparam logic [31:0] FRAME_WORDS = 32'(W * H);
    localparam logic [31:0] WU          = 32'(W);

    logic [9:0]     px_p, py_p, x_a, y_a;
    logic           vis_p, vis_a;
    logic [HCW-1:0] hc;

    logic           fs;
    logic [9:0]     x_n, y_n;
    logic           vis_n;
    logic [FW-1:0]  frame_n;
    logic           hit_c;
    logic [9:0]     col, row;
    logic [31:0]    addr_c;

    logic [ROM_LAT:0] in_d, br_d;
    logic [11:0]      bg_d [0:ROM_LAT];
    logic             transparent;

    function automatic logic near(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] d;
        d = (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
        return d <= 5'(KEY_TOL);
    endfunction

    assign fs = (hCount == 10'd0) && (vCount == 10'd0);

    // The values that become active at this FS are also used for the FS
    // pixel itself, so every address from that frame start onward sees the
    // new position and animation frame.
    always_comb begin
        x_n     = x_a;
        y_n     = y_a;
        vis_n   = vis_a;
        frame_n = cur_frame;
        if (fs) begin
            x_n   = pos_we ? pos_x : px_p;
            y_n   = pos_we ? pos_y : py_p;
            vis_n = vis_p;
            if (anim_en && hc == HCW'(FRAME_HOLD - 1))
                frame_n = (cur_frame == FW'(NUM_FRAMES - 1)) ? '0 : cur_frame + FW'(1);
        end
    end

    // 11-bit compares so a sprite near column/row 1023 is clipped, not wrapped.
    always_comb begin
        hit_c = vis_n && bright
             && ({1'b0, hCount} >= {1'b0, x_n}) && ({1'b0, hCount} < ({1'b0, x_n} + SPAN_X))
             && ({1'b0, vCount} >= {1'b0, y_n}) && ({1'b0, vCount} < ({1'b0, y_n} + SPAN_Y));
        col    = (hCount - x_n) >> SH;
        row    = (vCount - y_n) >> SH;
        addr_c = 32'(frame_n) * FRAME_WORDS + 32'(row) * WU + 32'(col);
    end

    assign transparent = near(rom_data[11:8], KEY_COLOR[11:8])
                      && near(rom_data[7:4],  KEY_COLOR[7:4])
                      && near(rom_data[3:0],  KEY_COLOR[3:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            px_p       <= 10'(INIT_X);
            py_p       <= 10'(INIT_Y);
            x_a        <= 10'(INIT_X);
            y_a        <= 10'(INIT_Y);
            vis_p      <= 1'b0;
            vis_a      <= 1'b0;
            hc         <= '0;
            cur_frame  <= '0;
            rom_addr   <= '0;
            in_d       <= '0;
            br_d       <= '0;
            for (int unsigned i = 0; i <= ROM_LAT; i++) bg_d[i] <= '0;
            rgb        <= '0;
            sprite_hit <= 1'b0;
        end else begin
            if (pos_we) begin
                px_p <= pos_x;
                py_p <= pos_y;
            end
            vis_p <= visible;

            if (fs) begin
                x_a       <= x_n;
                y_a       <= y_n;
                vis_a     <= vis_n;
                cur_frame <= frame_n;
                if (anim_en)
                    hc <= (hc == HCW'(FRAME_HOLD - 1)) ? '0 : hc + HCW'(1);
            end

            if (hit_c)
                rom_addr <= ADDR_W'(addr_c);

            // Delay line sized so stage ROM_LAT lines up with rom_data.
            in_d    <= {in_d[ROM_LAT-1:0], hit_c};
            br_d    <= {br_d[ROM_LAT-1:0], bright};
            bg_d[0] <= background;
            for (int unsigned i = 1; i <= ROM_LAT; i++) bg_d[i] <= bg_d[i-1];

            if (!br_d[ROM_LAT]) begin
                rgb        <= '0;
                sprite_hit <= 1'b0;
            end else if (in_d[ROM_LAT] && !transparent) begin
                rgb        <= rom_data;
                sprite_hit <= 1'b1;
            end else begin
                rgb        <= bg_d[ROM_LAT];
                sprite_hit <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sprite_engine.sv
// tb_sprite_engine
//   Directed bench for sprite_engine. Instance A: 32x32, 4 frames,
//   FRAME_HOLD=2, SCALE=1. Instance B: 32x32, 1 frame, SCALE=2. Both read a
//   shared ROM image held in the bench with one cycle latency.
module tb_sprite_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        bright;
    logic [9:0]  hCount, vCount;
    logic [11:0] background;
    logic [9:0]  pos_x, pos_y;
    logic        pos_we;
    logic        visible;
    logic        anim_en;

    logic [11:0] rom_addr_a;
    logic [11:0] rom_data_a;
    logic [11:0] rgb_a;
    logic        hit_a;
    logic [1:0]  frame_a;

    logic [9:0]  rom_addr_b;
    logic [11:0] rom_data_b;
    logic [11:0] rgb_b;
    logic        hit_b;
    logic [0:0]  frame_b;

    logic [11:0] mem [0:4095];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sprite_engine #(.FRAME_HOLD(2)) dut_a (
        .clk(clk), .rst(rst), .bright(bright), .hCount(hCount), .vCount(vCount),
        .background(background), .pos_x(pos_x), .pos_y(pos_y), .pos_we(pos_we),
        .visible(visible), .anim_en(anim_en), .rom_addr(rom_addr_a),
        .rom_data(rom_data_a), .rgb(rgb_a), .sprite_hit(hit_a), .cur_frame(frame_a)
    );

    sprite_engine #(.NUM_FRAMES(1), .SCALE(2)) dut_b (
        .clk(clk), .rst(rst), .bright(bright), .hCount(hCount), .vCount(vCount),
        .background(background), .pos_x(pos_x), .pos_y(pos_y), .pos_we(pos_we),
        .visible(visible), .anim_en(anim_en), .rom_addr(rom_addr_b),
        .rom_data(rom_data_b), .rgb(rgb_b), .sprite_hit(hit_b), .cur_frame(frame_b)
    );

    always @(posedge clk) begin
        rom_data_a <= mem[rom_addr_a];
        rom_data_b <= mem[{2'b00, rom_addr_b}];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [9:0] h, input logic [9:0] v,
                         input logic br, input logic [11:0] bg);
        hCount = h; vCount = v; bright = br; background = bg;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        drive(10'd800, 10'd600, 1'b0, 12'h000);
    endtask

    // One pixel followed by two idle pixels; on return rgb holds that pixel.
    task automatic probe(input logic [9:0] h, input logic [9:0] v,
                         input logic br, input logic [11:0] bg);
        drive(h, v, br, bg);
        tick;
        pos_we = 1'b0;
        idle;
        tick;
        tick;
    endtask

    task automatic frame_start;
        drive(10'd0, 10'd0, 1'b0, 12'h000);
        tick;
        pos_we = 1'b0;
        idle;
    endtask

    localparam int NFS = 10;

    initial begin
        logic [1:0] frame_seq [NFS];
        frame_seq = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0, 2'd1};

        // Sprite image: R nibble <= 7 keeps every entry opaque except the
        // four key-test pixels at the start of frame 0.
        for (int i = 0; i < 4096; i++) mem[i] = {1'b0, 11'(i)};
        mem[0] = 12'hF0F;
        mem[1] = 12'hE1E;
        mem[2] = 12'hF1F;
        mem[3] = 12'hD0F;

        rst = 1'b1; pos_x = '0; pos_y = '0; pos_we = 1'b0;
        visible = 1'b0; anim_en = 1'b0;
        idle;
        tick;
        tick;
        check("rst_rgb", rgb_a, 12'h000);
        check("rst_hit", hit_a, 1'b0);
        check("rst_addr", rom_addr_a, 12'd0);
        check("rst_frame", frame_a, 2'd0);
        rst = 1'b0;

        // Hidden until the first frame start with visible=1
        visible = 1'b1;
        tick;
        probe(10'd105, 10'd102, 1'b1, 12'h123);
        check("pre_fs_hidden", rgb_a, 12'h123);

        frame_start;
        probe(10'd100, 10'd100, 1'b1, 12'hABC);
        check("key_F0F", rgb_a, 12'hABC);
        check("key_F0F_hit", hit_a, 1'b0);
        probe(10'd101, 10'd100, 1'b1, 12'hABC);
        check("key_E1E", rgb_a, 12'hABC);
        probe(10'd102, 10'd100, 1'b1, 12'hABC);
        check("key_F1F", rgb_a, 12'hABC);
        probe(10'd103, 10'd100, 1'b1, 12'hABC);
        check("key_D0F", rgb_a, 12'hD0F);
        check("key_D0F_hit", hit_a, 1'b1);
        probe(10'd131, 10'd131, 1'b1, 12'hABC);
        check("corner_px", rgb_a, 12'h3FF);
        check("corner_addr", rom_addr_a, 12'd1023);
        probe(10'd132, 10'd100, 1'b1, 12'hABC);
        check("right_edge", rgb_a, 12'hABC);
        check("addr_hold", rom_addr_a, 12'd1023);
        probe(10'd99, 10'd100, 1'b1, 12'hABC);
        check("left_edge", rgb_a, 12'hABC);
        probe(10'd100, 10'd132, 1'b1, 12'hABC);
        check("bottom_edge", rgb_a, 12'hABC);
        probe(10'd110, 10'd105, 1'b0, 12'hABC);
        check("blank_rgb", rgb_a, 12'h000);
        check("blank_hit", hit_a, 1'b0);

        // Tear-free move
        pos_x = 10'd300; pos_y = 10'd50; pos_we = 1'b1;
        probe(10'd200, 10'd240, 1'b1, 12'hABC);
        probe(10'd105, 10'd102, 1'b1, 12'hABC);
        check("move_old_pos", rgb_a, 12'h045);
        probe(10'd305, 10'd52, 1'b1, 12'hABC);
        check("move_not_yet", rgb_a, 12'hABC);
        frame_start;
        probe(10'd302, 10'd51, 1'b1, 12'hABC);
        check("move_new_pos", rgb_a, 12'h022);
        probe(10'd105, 10'd102, 1'b1, 12'hABC);
        check("move_old_gone", rgb_a, 12'hABC);
        pos_x = 10'd310; pos_y = 10'd60; pos_we = 1'b1;
        frame_start;
        probe(10'd312, 10'd61, 1'b1, 12'hABC);
        check("fs_write", rgb_a, 12'h022);
        probe(10'd302, 10'd51, 1'b1, 12'hABC);
        check("fs_write_old", rgb_a, 12'hABC);

        // Animation
        anim_en = 1'b1;
        for (int k = 0; k < NFS; k++) begin
            frame_start;
            check($sformatf("anim_fs%0d", k + 1), frame_a, frame_seq[k]);
            if (k == 1 || k == 5) begin
                probe(10'd312, 10'd61, 1'b1, 12'hABC);
                check($sformatf("anim_addr%0d", k + 1), rom_addr_a,
                      32'(frame_seq[k]) * 1024 + 34);
                check($sformatf("anim_px%0d", k + 1), rgb_a, 12'h422);
            end
        end
        anim_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            frame_start;
            check($sformatf("anim_frozen%0d", k), frame_a, 2'd1);
        end

        // Reset in the middle of a sprite pixel
        drive(10'd312, 10'd61, 1'b1, 12'hABC);
        tick;
        rst = 1'b1;
        idle;
        tick;
        check("midrst_rgb", rgb_a, 12'h000);
        check("midrst_hit", hit_a, 1'b0);
        check("midrst_frame", frame_a, 2'd0);
        check("midrst_addr", rom_addr_a, 12'd0);
        rst = 1'b0;
        tick;
        check("midrst_flush", rgb_a, 12'h000);
        probe(10'd105, 10'd102, 1'b1, 12'h777);
        check("postrst_hidden", rgb_a, 12'h777);
        frame_start;
        probe(10'd105, 10'd102, 1'b1, 12'h777);
        check("postrst_draw", rgb_a, 12'h045);
        check("postrst_hit", hit_a, 1'b1);

        // Scale 2 with right-edge clipping (instance B)
        pos_x = 10'd1000; pos_y = 10'd470; pos_we = 1'b1;
        tick;
        pos_we = 1'b0;
        frame_start;
        probe(10'd1002, 10'd472, 1'b1, 12'h555);
        check("sc_r1c1_a", rgb_b, 12'h021);
        probe(10'd1003, 10'd473, 1'b1, 12'h555);
        check("sc_r1c1_b", rgb_b, 12'h021);
        check("sc_hit", hit_b, 1'b1);
        probe(10'd1001, 10'd473, 1'b1, 12'h555);
        check("sc_r1c0", rgb_b, 12'h020);
        probe(10'd1023, 10'd471, 1'b1, 12'h555);
        check("sc_clip_edge", rgb_b, 12'h00B);
        probe(10'd1010, 10'd533, 1'b1, 12'h555);
        check("sc_bottom_row", rgb_b, 12'h3E5);
        probe(10'd1010, 10'd534, 1'b1, 12'h555);
        check("sc_below", rgb_b, 12'h555);
        probe(10'd999, 10'd472, 1'b1, 12'h555);
        check("sc_left", rgb_b, 12'h555);
        probe(10'd5, 10'd471, 1'b1, 12'h555);
        check("sc_nowrap5", rgb_b, 12'h555);
        check("sc_nowrap5_hit", hit_b, 1'b0);
        probe(10'd39, 10'd472, 1'b1, 12'h555);
        check("sc_nowrap39", rgb_b, 12'h555);
        check("sc_frame", frame_b, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sprite_engine.md
# sprite_engine

Parametrised single-clock sprite renderer for the VGA path. It overlays a W×H (optionally 2× scaled) multi-frame sprite onto the incoming background pixel and takes sprite position updates that apply only at frame boundaries, so the sprite never tears. It also steps an animation frame counter, drives an external synchronous sprite ROM and applies a tolerance-based colour key for transparency. It sits between the background generator and the RGB output register.

## Interface
Parameters:
- W, 32, sprite width in source pixels
- H, 32, sprite height in source pixels
- NUM_FRAMES, 4, animation frames stored back-to-back in ROM
- FRAME_HOLD, 8, video frames each animation frame is shown (≥1)
- SCALE, 1, pixel replication factor (1 or 2)
- ROM_LAT, 1, ROM read latency in clk cycles (1 or 2)
- KEY_COLOR, 12'hF0F, transparent colour (R,G,B nibbles)
- KEY_TOL, 1, per-channel key tolerance (0–15)
- INIT_X, 100, reset X position
- INIT_Y, 100, reset Y position
- ADDR_W, $clog2(NUM_FRAMES*W*H), ROM address width

Ports:
- clk  in  1  pixel clock; single clock domain
- rst  in  1  synchronous, active-high reset
- bright  in  1  display-active flag
- hCount  in  10  current pixel column
- vCount  in  10  current pixel row
- background  in  12  pixel colour beneath the sprite
- pos_x  in  10  requested sprite left edge
- pos_y  in  10  requested sprite top edge
- pos_we  in  1  pos_x/pos_y write strobe
- visible  in  1  sprite enable (level, sampled at frame start)
- anim_en  in  1  animation advance enable
- rom_addr  out  ADDR_W  ROM read address
- rom_data  in  12  ROM pixel, valid ROM_LAT cycles after rom_addr
- rgb  out  12  output pixel
- sprite_hit  out  1  opaque sprite pixel on rgb this cycle
- cur_frame  out  $clog2(NUM_FRAMES)  displayed animation frame

## Operation
- Frame start (FS) is the cycle with hCount==0 && vCount==0.
- Pending registers px_p/py_p/vis_p:
  - pos_we loads px_p/py_p; the last write before FS wins.
  - A pos_we coincident with FS is the value applied at that FS.
  - vis_p tracks visible every cycle.
- At FS, active registers x_a, y_a and vis_a load from the pending registers. Active registers never change at any other time.
- Hit test, done in 11-bit unsigned arithmetic so edges near 1023 do not wrap: in = vis_a && bright && hCount ≥ x_a && hCount < x_a+W*SCALE && vCount ≥ y_a && vCount < y_a+H*SCALE. Parts of the sprite beyond the counter range are clipped.
- Address:
  - col = (hCount−x_a)/SCALE and row = (vCount−y_a)/SCALE (shift).
  - rom_addr = cur_frame*W*H + row*W + col, registered.
  - When not in, rom_addr holds its previous value.
- Animation:
  - Hold counter hc advances at FS only when anim_en=1.
  - When hc==FRAME_HOLD−1, hc returns to 0 and cur_frame increments, wrapping from NUM_FRAMES−1 to 0.
  - When anim_en=0, hc and cur_frame hold.
  - The updated cur_frame is used for addresses generated from that FS onward.
- Keying:
  - A pixel is transparent when |R−KR|≤KEY_TOL, |G−KG|≤KEY_TOL and |B−KB|≤KEY_TOL. Compute the differences in 5 bits; no nibble wrap.
- Output select, on the aligned pipeline stage:
  - bright=0: rgb=0.
  - in && !transparent: rgb=rom_data and sprite_hit=1.
  - Otherwise: rgb=background and sprite_hit=0.

## Timing
- Total latency from hCount/vCount/background to rgb is L = ROM_LAT+2 cycles:
  - 1 cycle for the address register.
  - ROM_LAT cycles for the ROM.
  - 1 cycle for the output register.
- bright, in and background are delayed through a matching shift register so that they align with rom_data.
- rgb, sprite_hit and cur_frame are registered outputs.
- Reset (synchronous, rst=1 at a clk edge), values the cycle after:
  - rgb=0, sprite_hit=0, rom_addr=0, cur_frame=0, hc=0.
  - x_a=px_p=INIT_X, y_a=py_p=INIT_Y, vis_a=vis_p=0.
  - All pipeline stages cleared.
- Reset asserted mid-line or mid-frame aborts everything in flight. The sprite stays hidden until the first FS with visible=1.

## Test plan
- **Static render:** reset; visible=1; W=H=32; key pixels at ROM addr 0; wait one FS. Required response:
  - rgb = ROM[(v−100)*32+(h−100)] at (h,v)=(100..131,100..131), L cycles late.
  - Keyed pixel → background; sprite_hit=1 only on opaque pixels.
- **Tear-free move:** pos_we with (300,50) at mid-frame (h=200,v=240). Required response:
  - The remainder of that frame still draws at (100,100).
  - The next frame draws at (300,50).
  - A second write (310,60) coincident with FS applies at that same FS.
- **Animation:** NUM_FRAMES=4, FRAME_HOLD=2, anim_en=1. Required response:
  - cur_frame sequence is 0,0,1,1,2,2,3,3,0 across FS events.
  - rom_addr base = cur_frame*1024.
  - With anim_en=0, cur_frame is frozen.
- **Scale/clip:** SCALE=2; pos=(1000,470). Required response:
  - Each ROM pixel is repeated 2×2.
  - Only h=1000..1023 are drawn.
  - No wrapped copy appears at h=0..39.
- **Key tolerance:** KEY_TOL=1. Required response:
  - ROM values F0F, E1E and F1F → background.
  - ROM value D0F → drawn.
- **Reset/blank:** rst mid-sprite. Required response:
  - The next cycle gives rgb=0 and cur_frame=0.
  - bright=0 inside the sprite area → rgb=0 after L cycles.
